// File: rtl/lia_dither_generator.sv
// lia_dither_generator: paced square/triangle dither source with scale, offset and saturation,
// emitting samples plus aligned reference and cycle-start markers for the lock-in demodulator.
package lia_pkg;
  localparam int word_width = 16;
endpackage

module lia_dither_generator
  import lia_pkg::*;
#(
  parameter int div_width   = 16,
  parameter int phase_width = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   waveform_sel,
  input  logic [div_width-1:0]   sample_div,
  input  logic [phase_width-1:0] phase_step,
  input  logic [word_width-1:0]  amplitude,
  input  logic [word_width-1:0]  offset,
  output logic [word_width-1:0]  sample_out,
  output logic                   sample_out_valid,
  output logic                   ref_out,
  output logic                   cycle_start
);
  localparam int w = word_width;
  localparam int p = phase_width;
  localparam logic [w-1:0] pos_full = {1'b0, {(w-1){1'b1}}};
  localparam logic [w-1:0] neg_full = {1'b1, {(w-2){1'b0}}, 1'b1};
  localparam logic [w-1:0] min_word = {1'b1, {(w-1){1'b0}}};
  localparam logic signed [2*w-1:0] sat_hi = {{(w+1){1'b0}}, {(w-1){1'b1}}};
  localparam logic signed [2*w-1:0] sat_lo = {{(w+1){1'b1}}, {(w-1){1'b0}}};

  logic [div_width-1:0] cnt_q, cnt_d;
  logic [p-1:0] phase_q, phase_d;
  logic wrap_q, wrap_d, v1_q, v1_d;
  logic [w-1:0] shape_q, shape_d;
  logic ref2_q, ref2_d, wrap2_q, wrap2_d, v2_q, v2_d;
  logic [w-1:0] sample_q, sample_d;
  logic ref_q, ref_d, cs_q, cs_d, valid_q, valid_d;

  logic tick;
  logic [p:0] sum;
  logic [p-2:0] q;
  logic [w-1:0] u, tri_shape, sq_shape;
  logic signed [2*w-1:0] prod, scaled, off_ext, total;

  always_comb begin
    tick = enable && (cnt_q >= sample_div);
    cnt_d = (enable && !tick) ? cnt_q + 1'b1 : '0;
    sum = {1'b0, phase_q} + {1'b0, phase_step};
    phase_d = !enable ? '0 : tick ? sum[p-1:0] : phase_q;
    wrap_d = !enable ? 1'b0 : tick ? sum[p] : wrap_q;
    v1_d = tick;
    // Triangle folds the lower phase bits on the falling half, then recentres around zero
    q = phase_q[p-1] ? ~phase_q[p-2:0] : phase_q[p-2:0];
    u = w'(q) << (w-p+1);
    tri_shape = u ^ min_word;
    sq_shape = phase_q[p-1] ? neg_full : pos_full;
    shape_d = v1_q ? (waveform_sel ? tri_shape : sq_shape) : shape_q;
    ref2_d = v1_q ? phase_q[p-1] : ref2_q;
    wrap2_d = v1_q ? wrap_q : wrap2_q;
    v2_d = enable && v1_q;
    prod = $signed(shape_q) * $signed(amplitude);
    scaled = prod >>> (w-1);
    off_ext = {{w{offset[w-1]}}, offset};
    total = scaled + off_ext;
    sample_d = !v2_q ? sample_q : total > sat_hi ? pos_full : total < sat_lo ? min_word : total[w-1:0];
    ref_d = v2_q ? ref2_q : ref_q;
    valid_d = enable && v2_q;
    cs_d = enable && v2_q && wrap2_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      phase_q <= '0;
      wrap_q <= 1'b0;
      v1_q <= 1'b0;
      shape_q <= '0;
      ref2_q <= 1'b0;
      wrap2_q <= 1'b0;
      v2_q <= 1'b0;
      sample_q <= '0;
      ref_q <= 1'b0;
      cs_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      phase_q <= phase_d;
      wrap_q <= wrap_d;
      v1_q <= v1_d;
      shape_q <= shape_d;
      ref2_q <= ref2_d;
      wrap2_q <= wrap2_d;
      v2_q <= v2_d;
      sample_q <= sample_d;
      ref_q <= ref_d;
      cs_q <= cs_d;
      valid_q <= valid_d;
    end
  end

  assign sample_out = sample_q;
  assign sample_out_valid = valid_q;
  assign ref_out = ref_q;
  assign cycle_start = cs_q;
endmodule

// File: doc/lia_dither_generator.md
# lia_dither_generator

Generates the dither/modulation sample stream that the lock-in amplifier later demodulates and low-pass filters. It is the transmit end of the LIA sample path. A programmable prescaler paces output samples, and a phase accumulator drives a square or triangle waveform. The waveform is scaled, offset and saturated, then emitted as a `sample_out`/`sample_out_valid` stream in the same format the filter chain consumes. It also outputs a square reference and a cycle-start marker, both aligned to the samples, for the demodulator.

## Interface
- `div_width`, 16: width of the prescaler divisor.
- `phase_width`, 10: phase accumulator width P. Must satisfy 2 ≤ P ≤ word_width+1.
- `word_width` is the shared package constant. Samples are signed two's complement.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  run control.
- `waveform_sel`  in  1  0 = square, 1 = triangle.
- `sample_div`  in  div_width  one sample every `sample_div`+1 cycles.
- `phase_step`  in  phase_width  phase increment per sample.
- `amplitude`  in  word_width  scale factor. Non-negative, 0..2^(w-1)-1.
- `offset`  in  word_width  signed DC offset.
- `sample_out`  out  word_width  signed output sample.
- `sample_out_valid`  out  1  one-cycle strobe per sample.
- `ref_out`  out  1  phase MSB of the current output sample.
- `cycle_start`  out  1  strobe with the sample whose phase update wrapped.

## Operation
- **Reset (`rst`=0), asynchronous:** all registers clear. Prescaler=0, phase=0, pipeline valids=0. `sample_out`=0, `sample_out_valid`=0, `ref_out`=0, `cycle_start`=0.
- **Prescaler:** counter increments each cycle while `enable`=1.
  - When counter ≥ `sample_div`, it issues a tick and clears to 0.
  - `sample_div` is compared live, so lowering it below the current count forces an immediate tick.
  - `sample_div`=0 gives a tick every cycle.
- **Stage 1 (on tick):** phase ← phase + `phase_step` mod 2^P, with `phase_step` sampled here. Carry-out is recorded as the wrap flag.
- **Stage 2, shape (w = word_width):**
  - Square: phase MSB=0 gives +(2^(w-1)-1); MSB=1 gives -(2^(w-1)-1).
  - Triangle, step 1: q = MSB ? ~phase[P-2:0] : phase[P-2:0].
  - Triangle, step 2: U = q << (w-P+1), treated as unsigned.
  - Triangle, step 3: shape = U - 2^(w-1).
- **Stage 3, output:**
  - scaled = (shape × `amplitude`) >>> (w-1), using an arithmetic (floor) shift and a 2w-bit product.
  - `sample_out` = saturate(scaled + `offset`) to [-2^(w-1), 2^(w-1)-1].
  - `amplitude` and `offset` are sampled at this stage.
  - `ref_out` and `cycle_start` register together with `sample_out`.
- **`enable`=0:**
  - Prescaler and phase clear synchronously.
  - In-flight stage valids are dropped, so no `sample_out_valid` occurs after the deassert edge.
  - `sample_out` and `ref_out` hold their last values. `cycle_start` is 0.
- `waveform_sel` changes take effect on the next sample reaching stage 2. No glitch suppression.

## Timing
- Tick at edge E0, when the counter is at terminal count and phase updates. Shape registers at E1. `sample_out` and `sample_out_valid` register at E2.
- Phase-update-to-output latency: 2 cycles. Throughput: 1 sample per `sample_div`+1 cycles, which allows continuous valid.
- After `enable` rises: first phase update at the (`sample_div`+1)-th edge, first valid 2 edges later. The first sample's phase equals `phase_step`.
- `sample_out_valid` and `cycle_start` are exactly one cycle wide unless `sample_div`=0.
- If `enable` falls and rises on consecutive cycles, the restart is clean from phase 0.

## Test plan
(word_width=16, P=10)
- **Reset mid-stream:** pull `rst` low asynchronously between edges while valid pulses are running -> all outputs are 0 immediately. After release with `enable`=1 and `sample_div`=3, the first valid arrives 6 edges later.
- **Square:** `sample_div`=3, `phase_step`=64, `amplitude`=16384, `offset`=0 ->
  - valid every 4 cycles;
  - samples 1–7 (phases 64..448) = +16383 with `ref_out`=0;
  - samples 8–15 (phases 512..960) = -16384 with `ref_out`=1;
  - sample 16 (phase 0) = +16383 with `cycle_start`=1.
- **Triangle:** `sample_div`=0, `phase_step`=128, `amplitude`=32767 ->
  - valid continuously high;
  - phase 128 gives -16384;
  - phase 256 gives 0 (U=32768);
  - phase 640 gives q=383, U=49024, shape=16256, output 16255.
- **Saturation:** square, `amplitude`=32767, `offset`=30000 -> high half = +32767 (clamped from 62766), low half = -2767. Then `offset`=-30000 -> low half clamps to -32768.
- **Enable toggle:** deassert `enable` one cycle after a tick -> no further valids, `sample_out` holds. Reassert -> first sample has phase=`phase_step`, arriving `sample_div`+3 edges after the reassert.
- **Divisor change:** with the counter at 10 and `sample_div` going from 20 to 5 -> tick on the next edge, then a period of 6 cycles.
